gshare_bht: RTL and testbench

Parametrised gshare branch predictor, successor to the fetch-stage 2-bit BHT. It keeps a table of saturating counters indexed by PC XOR global history, with a speculative global history register (GHR) that is repaired on mispredict. Table init is a multi-cycle hardware sweep, not a single-cycle reset loop. It sits beside fetch: lookup uses the fetch PC, and updates come from the branch-resolve stage.

---
 rtl/gshare_bht_if.sv | 27 ++
 rtl/gshare_bht.sv | 93 +++++++++
 tb/tb_gshare_bht.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_bht_if.sv
// Fetch/resolve-side bus of the gshare predictor: lookup request, prediction, resolve update.
interface gshare_bht_if #(
  parameter int unsigned HIST_BITS = 8
);
  logic [31:0]          lookup_PC;
  logic                 lookup_valid;
  logic                 predict_taken;
  logic [HIST_BITS-1:0] predict_hist;
  logic                 predict_ready;
  logic                 update_enable;
  logic [31:0]          update_PC;
  logic                 update_taken;
  logic [HIST_BITS-1:0] update_hist;
  logic                 update_mispredict;

  modport master (
    output lookup_PC, lookup_valid, update_enable, update_PC, update_taken, update_hist,
           update_mispredict,
    input  predict_taken, predict_hist, predict_ready
  );

  modport slave (
    input  lookup_PC, lookup_valid, update_enable, update_PC, update_taken, update_hist,
           update_mispredict,
    output predict_taken, predict_hist, predict_ready
  );
endinterface

// File: rtl/gshare_bht.sv
// gshare branch predictor: saturating counters indexed by PC ^ speculative global history,
// initialised by a one-entry-per-cycle hardware sweep after reset.
module gshare_bht #(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned INIT_VAL   = 1
) (
  input logic        clk,
  input logic        rst,
  gshare_bht_if.slave bus
);

  localparam int unsigned Depth = 2 ** INDEX_BITS;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [CNT_BITS-1:0]   table_q [Depth];

  logic                  we;
  logic [INDEX_BITS-1:0] waddr;
  logic [CNT_BITS-1:0]   wdata;
  logic [CNT_BITS-1:0]   upd_cnt;
  logic [INDEX_BITS-1:0] lookup_idx, update_idx;
  logic                  pred;

  assign lookup_idx = bus.lookup_PC[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign update_idx = bus.update_PC[INDEX_BITS+1:2] ^ INDEX_BITS'(bus.update_hist);
  assign upd_cnt    = table_q[update_idx];

  logic unused_pc;
  assign unused_pc = ^{bus.lookup_PC[31:INDEX_BITS+2], bus.lookup_PC[1:0],
                       bus.update_PC[31:INDEX_BITS+2], bus.update_PC[1:0]};

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    we      = 1'b0;
    waddr   = sweep_q;
    wdata   = CNT_BITS'(INIT_VAL);
    pred    = 1'b0;
    unique case (state_q)
      StInit: begin
        we      = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == INDEX_BITS'(Depth - 1)) state_d = StReady;
      end
      StReady: begin
        pred = table_q[lookup_idx][CNT_BITS-1];
        if (bus.update_enable) begin
          we    = 1'b1;
          waddr = update_idx;
          if (bus.update_taken) wdata = (&upd_cnt) ? upd_cnt : upd_cnt + 1'b1;
          else                  wdata = (|upd_cnt) ? upd_cnt - 1'b1 : upd_cnt;
        end
        // Repair from the resolved branch outranks this cycle's speculative shift.
        // Truncating {hist, bit} keeps the low HIST_BITS, which also covers HIST_BITS == 1.
        if (bus.update_enable && bus.update_mispredict) begin
          ghr_d = HIST_BITS'({bus.update_hist, bus.update_taken});
        end else if (bus.lookup_valid) begin
          ghr_d = HIST_BITS'({ghr_q, pred});
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign bus.predict_taken = pred;
  assign bus.predict_hist  = ghr_q;
  assign bus.predict_ready = (state_q == StReady);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Single write port shared by the sweep and resolve updates; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) table_q[waddr] <= wdata;
  end

endmodule

// File: tb/tb_gshare_bht.sv
// Bench for gshare_bht: 16-entry tables, 3-bit history, 2-bit and 3-bit counter variants.
module tb_gshare_bht;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_bht_if #(.HIST_BITS(3)) bus ();
  gshare_bht_if #(.HIST_BITS(3)) bus3 ();

  gshare_bht #(.INDEX_BITS(4), .CNT_BITS(2), .HIST_BITS(3), .INIT_VAL(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gshare_bht #(.INDEX_BITS(4), .CNT_BITS(3), .HIST_BITS(3), .INIT_VAL(1)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  task automatic idle();
    bus.lookup_valid = 0;  bus.lookup_PC = '0;   bus.update_enable = 0;
    bus.update_PC = '0;    bus.update_taken = 0; bus.update_hist = '0; bus.update_mispredict = 0;
    bus3.lookup_valid = 0; bus3.lookup_PC = '0;  bus3.update_enable = 0;
    bus3.update_PC = '0;   bus3.update_taken = 0; bus3.update_hist = '0;
    bus3.update_mispredict = 0;
  endtask

  // One resolve update on the 2-bit instance, returning at the following negedge.
  task automatic upd(input logic [31:0] pc, input logic [2:0] h, input logic t, input logic m);
    @(negedge clk);
    bus.update_enable = 1; bus.update_PC = pc; bus.update_hist = h;
    bus.update_taken = t;  bus.update_mispredict = m;
    @(negedge clk);
    bus.update_enable = 0; bus.update_mispredict = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #12;
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_ready) !== e) begin
      miscompares++; $display("FAIL reset_ready: got %0d want %0d", bus.predict_ready, e);
    end
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL reset_hist: got %0d want %0d", bus.predict_hist, e);
    end
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL reset_taken: got %0d want %0d", bus.predict_taken, e);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(8'(i == 16));
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_ready) !== e) begin
        miscompares++; $display("FAIL init_ready[%0d]: got %0d want %0d", i, bus.predict_ready, e);
      end
      exp_q.push_back(8'(i == 16));
      e = exp_q.pop_front(); vectors++;
      if (8'(bus3.predict_ready) !== e) begin
        miscompares++; $display("FAIL init_ready3[%0d]: got %0d want %0d", i, bus3.predict_ready, e);
      end
      exp_q.push_back(8'd0);
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_hist) !== e) begin
        miscompares++; $display("FAIL init_hist[%0d]: got %0d want %0d", i, bus.predict_hist, e);
      end
      // Traffic aimed at entry 7, already swept, must be ignored while initialising.
      if (i >= 8 && i <= 14) begin
        bus.update_enable = 1; bus.update_taken = 1; bus.update_mispredict = 1;
        bus.update_PC = 32'h0; bus.update_hist = 3'b111;
        bus.lookup_valid = 1;  bus.lookup_PC = 32'h4;
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_init_table();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.lookup_PC = 32'(i) << 2; bus3.lookup_PC = 32'(i) << 2;
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_taken) !== e) begin
        miscompares++; $display("FAIL init_entry[%0d]: got %0d want %0d", i, bus.predict_taken, e);
      end
      e = exp_q.pop_front(); vectors++;
      if (8'(bus3.predict_taken) !== e) begin
        miscompares++; $display("FAIL init_entry3[%0d]: got %0d want %0d", i, bus3.predict_taken, e);
      end
    end
  endtask

  task automatic test_saturation();
    bit dir2 [6]  = '{1, 1, 1, 1, 0, 0};
    bit want2 [6] = '{1, 1, 1, 1, 1, 0};
    bit dir3 [12]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit want3 [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      upd(32'h44, 3'b000, dir2[i], 1'b0);
      bus.lookup_PC = 32'h44;
      exp_q.push_back(8'(want2[i]));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_taken) !== e) begin
        miscompares++; $display("FAIL sat2[%0d]: got %0d want %0d", i, bus.predict_taken, e);
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus3.update_enable = 1; bus3.update_PC = 32'h44; bus3.update_taken = dir3[i];
      @(negedge clk);
      bus3.update_enable = 0; bus3.lookup_PC = 32'h44;
      exp_q.push_back(8'(want3[i]));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (8'(bus3.predict_taken) !== e) begin
        miscompares++; $display("FAIL sat3[%0d]: got %0d want %0d", i, bus3.predict_taken, e);
      end
    end
  endtask

  task automatic test_history();
    upd(32'h60, 3'b001, 1'b1, 1'b0);  // entry 9 -> 2
    upd(32'h60, 3'b001, 1'b1, 1'b0);  // entry 9 -> 3
    upd(32'h60, 3'b010, 1'b0, 1'b0);  // entry 10 -> 0
    bus.lookup_PC = 32'h60;
    exp_q.push_back(8'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL hist_000: got %0d want %0d", bus.predict_taken, e);
    end
    upd(32'h3C, 3'b000, 1'b1, 1'b1);  // GHR <- 001
    bus.lookup_PC = 32'h60;
    exp_q.push_back(8'd1); exp_q.push_back(8'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL hist_ghr01: got %0d want %0d", bus.predict_hist, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL hist_01: got %0d want %0d", bus.predict_taken, e);
    end
    upd(32'h3C, 3'b001, 1'b0, 1'b1);  // GHR <- 010
    bus.lookup_PC = 32'h60;
    exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL hist_ghr10: got %0d want %0d", bus.predict_hist, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL hist_10: got %0d want %0d", bus.predict_taken, e);
    end
  endtask

  task automatic test_ghr_repair();
    logic [31:0] pcs [3]  = '{32'h64, 32'h6C, 32'h6C};
    logic [7:0]  pred [3] = '{8'd1, 8'd0, 8'd1};
    logic [7:0]  hist [3] = '{8'd0, 8'd1, 8'd2};
    upd(32'h3C, 3'b000, 1'b0, 1'b1);  // GHR <- 000
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus.lookup_valid = 1; bus.lookup_PC = pcs[i];
      exp_q.push_back(pred[i]); exp_q.push_back(hist[i]);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_taken) !== e) begin
        miscompares++; $display("FAIL spec_pred[%0d]: got %0d want %0d", i, bus.predict_taken, e);
      end
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_hist) !== e) begin
        miscompares++; $display("FAIL spec_hist[%0d]: got %0d want %0d", i, bus.predict_hist, e);
      end
    end
    @(negedge clk);
    bus.lookup_valid = 0;
    exp_q.push_back(8'b101);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL spec_ghr: got %0d want %0d", bus.predict_hist, e);
    end
    // Lookup here predicts taken, so a wrongly applied shift would give 011.
    @(negedge clk);
    bus.lookup_valid = 1; bus.lookup_PC = 32'h70;
    bus.update_enable = 1; bus.update_mispredict = 1; bus.update_PC = 32'h3C;
    bus.update_hist = 3'b001; bus.update_taken = 0;
    @(negedge clk);
    idle();
    exp_q.push_back(8'b010);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL repair_ghr: got %0d want %0d", bus.predict_hist, e);
    end
    upd(32'h3C, 3'b000, 1'b1, 1'b0);
    exp_q.push_back(8'b010);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL no_misp_ghr: got %0d want %0d", bus.predict_hist, e);
    end
  endtask

  task automatic test_read_before_write();
    // GHR = 010; lookup 0x44 and update 0x0C/hist 000 both map to entry 3 (counter 1).
    @(negedge clk);
    bus.lookup_PC = 32'h44;
    bus.update_enable = 1; bus.update_PC = 32'h0C; bus.update_hist = 3'b000; bus.update_taken = 1;
    exp_q.push_back(8'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL rbw_same: got %0d want %0d", bus.predict_taken, e);
    end
    @(negedge clk);
    bus.update_enable = 0;
    exp_q.push_back(8'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_taken) !== e) begin
      miscompares++; $display("FAIL rbw_next: got %0d want %0d", bus.predict_taken, e);
    end
  endtask

  task automatic test_back_to_back();
    // Entry 5 (counter 1) updated every cycle while looked up; each cycle sees the pre-update value.
    bit dir [8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit want [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    bus.lookup_PC = 32'h1C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.update_enable = 1; bus.update_PC = 32'h14; bus.update_hist = 3'b000;
      bus.update_taken = dir[i];
      exp_q.push_back(8'(want[i]));
      #1;
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_taken) !== e) begin
        miscompares++; $display("FAIL b2b[%0d]: got %0d want %0d", i, bus.predict_taken, e);
      end
    end
    @(negedge clk);
    bus.update_enable = 0;
  endtask

  task automatic test_reset_midsweep();
    @(negedge clk);
    rst = 0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_ready) !== e) begin
      miscompares++; $display("FAIL midop_ready: got %0d want %0d", bus.predict_ready, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (8'(bus.predict_hist) !== e) begin
      miscompares++; $display("FAIL midop_hist: got %0d want %0d", bus.predict_hist, e);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(8'd0);
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_ready) !== e) begin
        miscompares++; $display("FAIL sweep1_ready[%0d]: got %0d want %0d", i, bus.predict_ready, e);
      end
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(8'(i == 16));
      e = exp_q.pop_front(); vectors++;
      if (8'(bus.predict_ready) !== e) begin
        miscompares++; $display("FAIL sweep2_ready[%0d]: got %0d want %0d", i, bus.predict_ready, e);
      end
    end
    test_init_table();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_table();
    test_saturation();
    test_history();
    test_ghr_repair();
    test_read_before_write();
    test_back_to_back();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
